// File: rtl/riscv_pkg.sv
// Shared RV32I constants: data width and load/store funct3 encodings.
// No ports; imported by the MEM stage and its data RAM.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM: asynchronous read, byte-enabled synchronous write.
// Ports: clk, we, be[3:0] lane enables, addr word index, wdata, rdata.
module data_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with data RAM, load extension, fault decode and MEM/WB register.
// Ports: clk, rst, stall, EX/MEM inputs (*_mem_in, *M), WB outputs (*_W), mem_err.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] alu_mem_in,
    input  logic [31:0] RD2_mem_in,
    input  logic [4:0]  A3_mem_in,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3_mem_in,
    output logic [31:0] ReadData_W,
    output logic [31:0] alu_W,
    output logic [4:0]  A3_W,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        mem_err
);

    logic [1:0]        w_lo;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused;
    logic [31:0]       w_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic              w_misalign;
    logic              w_fault;
    logic              w_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    assign w_lo     = alu_mem_in[1:0];
    assign w_idx    = alu_mem_in[ADDR_W+1:2];
    // Address bits above the RAM are ignored so accesses wrap.
    assign w_unused = ^alu_mem_in[31:ADDR_W+2];

    // funct3[1:0] encodes access size for both loads and stores.
    always_comb begin
        w_misalign = 1'b0;
        case (funct3_mem_in[1:0])
            2'b01:   w_misalign = w_lo[0];
            2'b10:   w_misalign = (w_lo != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_fault = 1'b0;
        if (MemtoRegM && MemWriteM) begin
            w_fault = 1'b1;
        end else if (MemtoRegM) begin
            case (funct3_mem_in)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_fault = w_misalign;
                default:                        w_fault = 1'b1;
            endcase
        end else if (MemWriteM) begin
            case (funct3_mem_in)
                F3_B, F3_H, F3_W: w_fault = w_misalign;
                default:          w_fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = RD2_mem_in;
        case (funct3_mem_in)
            F3_B: begin
                w_be    = 4'b0001 << w_lo;
                w_wdata = {4{RD2_mem_in[7:0]}};
            end
            F3_H: begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{RD2_mem_in[15:0]}};
            end
            F3_W: begin
                w_be    = 4'b1111;
                w_wdata = RD2_mem_in;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = RD2_mem_in;
            end
        endcase
    end

    assign w_we = MemWriteM && !MemtoRegM && !w_fault && !stall && !rst;

    data_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .be    (w_be),
        .addr  (w_idx),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    assign w_byte = w_rdata[8*w_lo +: 8];
    assign w_half = w_lo[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_ext = 32'd0;
        case (funct3_mem_in)
            F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
            F3_H:    w_ext = {{16{w_half[15]}}, w_half};
            F3_W:    w_ext = w_rdata;
            F3_BU:   w_ext = {24'd0, w_byte};
            F3_HU:   w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ReadData_W <= 32'd0;
            alu_W      <= 32'd0;
            A3_W       <= 5'd0;
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            mem_err    <= 1'b0;
        end else if (!stall) begin
            ReadData_W <= w_fault ? 32'd0 : w_ext;
            alu_W      <= alu_mem_in;
            A3_W       <= A3_mem_in;
            RegWriteW  <= RegWriteM && !w_fault;
            MemtoRegW  <= MemtoRegM;
            mem_err    <= mem_err || w_fault;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a byte-array reference model.
// Model predicts every registered output; a negedge process compares.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] alu_mem_in, RD2_mem_in;
    logic [4:0]  A3_mem_in;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [2:0]  funct3_mem_in;
    logic [31:0] ReadData_W, alu_W;
    logic [4:0]  A3_W;
    logic        RegWriteW, MemtoRegW, mem_err;

    int errors = 0;
    int checks = 0;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .alu_mem_in    (alu_mem_in),
        .RD2_mem_in    (RD2_mem_in),
        .A3_mem_in     (A3_mem_in),
        .RegWriteM     (RegWriteM),
        .MemtoRegM     (MemtoRegM),
        .MemWriteM     (MemWriteM),
        .funct3_mem_in (funct3_mem_in),
        .ReadData_W    (ReadData_W),
        .alu_W         (alu_W),
        .A3_W          (A3_W),
        .RegWriteW     (RegWriteW),
        .MemtoRegW     (MemtoRegW),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    // Reference model: 1 KiB byte memory plus expected output registers.
    logic [7:0]  mmem [1024];
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_a3;
    logic        e_rw, e_m2r, e_err, e_rdv;
    logic        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_W", alu_W, e_alu);
            chk("A3_W", {27'd0, A3_W}, {27'd0, e_a3});
            chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e_rw});
            chk("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, e_m2r});
            chk("mem_err", {31'd0, mem_err}, {31'd0, e_err});
            if (e_rdv) chk("ReadData_W", ReadData_W, e_rd);
        end
    end

    function automatic logic mfault(input logic ld, input logic st,
                                    input logic [2:0] f3, input logic [31:0] a);
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (st && f3 > 3'd2) return 1'b1;
        if (f3[1:0] == 2'd1) return a[0];
        if (f3[1:0] == 2'd2) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a);
        int b, h;
        logic [31:0] w;
        b = int'(a[9:0]);
        h = int'({a[9:1], 1'b0});
        w = {mmem[b | 3], mmem[(b & ~3) | 2], mmem[(b & ~3) | 1], mmem[b & ~3]};
        case (f3)
            3'd0: return {{24{mmem[b][7]}}, mmem[b]};
            3'd1: return {{16{mmem[h+1][7]}}, mmem[h+1], mmem[h]};
            3'd2: return w;
            3'd4: return {24'd0, mmem[b]};
            3'd5: return {16'd0, mmem[h+1], mmem[h]};
            default: return 32'd0;
        endcase
    endfunction

    // Drive one instruction for one cycle; called and returns at negedge.
    task automatic step(input logic r, input logic s, input logic ld, input logic st,
                        input logic rw, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
        logic f;
        int b;
        rst = r; stall = s; MemtoRegM = ld; MemWriteM = st; RegWriteM = rw;
        funct3_mem_in = f3; alu_mem_in = a; RD2_mem_in = d; A3_mem_in = rd;
        f = mfault(ld, st, f3, a);
        b = int'(a[9:0]);
        @(posedge clk);
        if (r) begin
            e_rd = 0; e_alu = 0; e_a3 = 0; e_rw = 0; e_m2r = 0; e_err = 0; e_rdv = 1;
        end else if (!s) begin
            e_rd  = f ? 32'd0 : mload(f3, a);
            e_rdv = ld;
            e_alu = a; e_a3 = rd; e_rw = rw && !f; e_m2r = ld;
            e_err = e_err || f;
            if (st && !ld && !f) begin
                if (f3 == 3'd0) mmem[b] = d[7:0];
                if (f3 == 3'd1) {mmem[b+1], mmem[b]} = d[15:0];
                if (f3 == 3'd2) {mmem[b+3], mmem[b+2], mmem[b+1], mmem[b]} = d;
            end
        end
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        step(0, 0, 0, 1, 0, 3'd2, a, d, 5'd0);
    endtask

    task automatic ldx(input logic [2:0] f3, input logic [31:0] a);
        step(0, 0, 1, 0, 1, f3, a, $urandom, 5'd7);
    endtask

    task automatic rst_rand;
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, $urandom_range(0, 1),
             3'd2, 32'h40, $urandom, 5'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mmem[i] = 8'h00;
        e_rd = 0; e_alu = 0; e_a3 = 0; e_rw = 0; e_m2r = 0; e_err = 0; e_rdv = 0;
        rst = 1; stall = 0; MemtoRegM = 0; MemWriteM = 0; RegWriteM = 0;
        funct3_mem_in = 0; alu_mem_in = 0; RD2_mem_in = 0; A3_mem_in = 0;
        @(negedge clk);

        rst_rand; rst_rand;
        chk("rst alu_W", alu_W, 32'd0);
        chk("rst mem_err", {31'd0, mem_err}, 32'd0);

        sw(32'h10, 32'hDEADBEEF);
        ldx(3'd2, 32'h10);
        chk("LW 0x10", ReadData_W, 32'hDEADBEEF);
        ldx(3'd0, 32'h13);
        chk("LB 0x13", ReadData_W, 32'hFFFFFFDE);
        ldx(3'd4, 32'h13);
        chk("LBU 0x13", ReadData_W, 32'h000000DE);

        sw(32'h10, 32'h11223344);
        step(0, 0, 0, 1, 0, 3'd0, 32'h11, 32'h000000AA, 5'd0);
        ldx(3'd2, 32'h10);
        chk("SB merge", ReadData_W, 32'h1122AA44);
        ldx(3'd1, 32'h12);
        chk("LH 0x12", ReadData_W, 32'h00001122);
        ldx(3'd5, 32'h10);
        chk("LHU 0x10", ReadData_W, 32'h0000AA44);
        ldx(3'd1, 32'h10);
        chk("LH sign", ReadData_W, 32'hFFFFAA44);

        sw(32'h20, 32'h87654321);
        ldx(3'd2, 32'h06);
        chk("LW mis rd", ReadData_W, 32'd0);
        chk("LW mis rw", {31'd0, RegWriteW}, 32'd0);
        chk("LW mis err", {31'd0, mem_err}, 32'd1);
        step(0, 0, 0, 1, 0, 3'd1, 32'h21, 32'hFFFF, 5'd0);
        step(0, 0, 1, 1, 1, 3'd2, 32'h20, 32'h0, 5'd3);
        step(0, 0, 0, 1, 0, 3'd3, 32'h20, 32'h0, 5'd0);
        ldx(3'd3, 32'h20);
        ldx(3'd2, 32'h20);
        chk("SH mis no wr", ReadData_W, 32'h87654321);
        chk("err sticky", {31'd0, mem_err}, 32'd1);

        ldx(3'd2, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 0, 3'd2, 32'h30, 32'h0BADF00D, 5'd0);
            chk("stall frozen", ReadData_W, 32'h1122AA44);
        end
        step(0, 0, 0, 1, 0, 3'd2, 32'h30, 32'h0BADF00D, 5'd0);
        ldx(3'd2, 32'h30);
        chk("stall release", ReadData_W, 32'h0BADF00D);

        sw(32'h408, 32'h5A5A5A5A);
        ldx(3'd2, 32'h08);
        chk("wrap", ReadData_W, 32'h5A5A5A5A);
        step(0, 0, 0, 0, 1, 3'd7, 32'h1234, 32'h0, 5'd9);
        chk("nonmem alu", alu_W, 32'h1234);
        chk("nonmem rw", {31'd0, RegWriteW}, 32'd1);

        sw(32'h40, 32'hCAFEF00D);
        rst_rand; rst_rand;
        chk("rst2 err", {31'd0, mem_err}, 32'd0);
        ldx(3'd2, 32'h40);
        chk("rst no store", ReadData_W, 32'hCAFEF00D);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
